if_fetch_unit: RTL and testbench

//  Parametrised fetch front-end for the OpenMIPS pipeline. Replaces the pc_reg + if_id pair.

---
 rtl/if_fetch_unit_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/if_fetch_unit.sv | 88 ++++++++
 tb/tb_if_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the fetch front-end: bus widths, default queue depth
// and the NOP word presented to ID when nothing valid is buffered.
package if_fetch_unit_pkg;

    localparam int INST_ADDR_W   = 32;
    localparam int INST_DATA_W   = 32;
    localparam int FETCH_Q_DEPTH = 4;

    localparam logic [INST_DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead queue of fetched {pc, inst} pairs. Clear beats push/pop so a
// redirect can never leave a stale entry behind. Storage is not reset; only
// the pointers and occupancy are.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int WIDTH = INST_ADDR_W + INST_DATA_W,
    parameter int DEPTH = FETCH_Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front-end: owns the PC and ROM enable, pushes each fetched word into
// a small queue and presents the queue head to ID. ID may stall without loss;
// a flush from ID empties the queue and redirects the PC.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                INST_W   = INST_DATA_W,
    parameter int                DEPTH    = FETCH_Q_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
);

    localparam int WIDTH = ADDR_W + INST_W;

    logic [ADDR_W-1:0]       pc;
    logic                    ce_q;
    logic                    fetch;
    logic                    pop;
    logic [WIDTH-1:0]        fifo_head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [$clog2(DEPTH):0]  fifo_count;

    // Reset is folded into the handshakes so nothing leaks out while rst is
    // high, even if the queue still holds entries from before it asserted.
    assign id_valid_o = ~rst & ~fifo_empty;
    assign pop        = id_valid_o & ~stall_i;
    assign fetch      = ce_q & ~rst & ~flush_i & (~fifo_full | pop);

    assign rom_ce_o   = fetch;
    assign rom_addr_o = pc;

    // An empty queue shows a NOP rather than stale storage contents.
    assign id_pc_o    = id_valid_o ? fifo_head[WIDTH-1:INST_W] : '0;
    assign id_inst_o  = id_valid_o ? fifo_head[INST_W-1:0]     : ZERO_WORD[INST_W-1:0];

    // PC and ROM enable: redirect wins over the sequential increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            ce_q <= 1'b0;
        end else begin
            ce_q <= 1'b1;
            if (flush_i) begin
                pc <= new_pc_i;
            end else if (fetch) begin
                pc <= pc + ADDR_W'(PC_STEP);
            end
        end
    end

    // Occupancy count and empty flag must always describe the same state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((fifo_count == '0) == fifo_empty);
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_i),
        .push  (fetch),
        .pop   (pop),
        .din   ({pc, rom_data_i}),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for the fetch front-end. ROM model returns the word index
// (address >> 2), so every instruction value can be derived from its PC.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ce;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_data;
    logic        w_rom_ce;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_inst;

    int checks;
    int errors;

    assign rom_data   = {2'b00, rom_addr[31:2]};
    assign w_rom_data = {2'b00, w_rom_addr[31:2]};

    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_data_i (rom_data),
        .rom_addr_o (rom_addr),
        .rom_ce_o   (rom_ce),
        .stall_i    (stall),
        .flush_i    (flush),
        .new_pc_i   (new_pc),
        .id_valid_o (id_valid),
        .id_pc_o    (id_pc),
        .id_inst_o  (id_inst)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .rom_data_i (w_rom_data),
        .rom_addr_o (w_rom_addr),
        .rom_ce_o   (w_rom_ce),
        .stall_i    (stall),
        .flush_i    (flush),
        .new_pc_i   (new_pc),
        .id_valid_o (w_id_valid),
        .id_pc_o    (w_id_pc),
        .id_inst_o  (w_id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] wexp [4];
        int nf;
        checks = 0;
        errors = 0;
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        wexp[3] = 32'h0000_0004;

        // Reset for three cycles, then release with no stall.
        rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
        repeat (3) cyc();
        chk("rst_ce",   {31'b0, rom_ce},   32'h0);
        chk("rst_vld",  {31'b0, id_valid}, 32'h0);
        chk("rst_pc",   id_pc,             32'h0);
        chk("rst_inst", id_inst,           32'h0);
        chk("rst_addr", rom_addr,          32'h0);
        rst = 1'b0;
        #1;
        chk("rel_ce",  {31'b0, rom_ce},   32'h0);
        chk("rel_vld", {31'b0, id_valid}, 32'h0);
        cyc();
        chk("c1_ce",   {31'b0, rom_ce},   32'h1);
        chk("c1_addr", rom_addr,          32'h0);
        chk("c1_vld",  {31'b0, id_valid}, 32'h0);
        chk("w_c1_addr", w_rom_addr,      32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("seq_vld",  {31'b0, id_valid}, 32'h1);
            chk("seq_pc",   id_pc,             32'(4 * i));
            chk("seq_inst", id_inst,           32'(i));
            chk("wrap_pc",  w_id_pc,           wexp[i]);
            chk("wrap_inst", w_id_inst,        {2'b00, wexp[i][31:2]});
        end

        // Fill under stall from a fresh reset: four fetches then hold.
        rst = 1'b1;
        cyc();
        rst = 1'b0; stall = 1'b1;
        #1;
        cyc();
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            nf += int'(rom_ce);
            cyc();
        end
        chk("fill_nfetch", 32'(nf),           32'd4);
        chk("fill_ce",     {31'b0, rom_ce},   32'h0);
        chk("fill_addr",   rom_addr,          32'd16);
        chk("fill_vld",    {31'b0, id_valid}, 32'h1);
        chk("fill_head",   id_pc,             32'h0);

        // Release stall on a full queue: push and pop every cycle.
        stall = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_vld",  {31'b0, id_valid}, 32'h1);
            chk("drain_pc",   id_pc,             32'(4 * i));
            chk("drain_inst", id_inst,           32'(i));
            chk("drain_ce",   {31'b0, rom_ce},   32'h1);
            cyc();
        end

        // Flush with stall on a non-empty queue.
        flush = 1'b1; new_pc = 32'h100; stall = 1'b1;
        #1;
        chk("fl_ce", {31'b0, rom_ce}, 32'h0);
        cyc();
        flush = 1'b0; stall = 1'b0;
        #1;
        chk("fl1_vld",  {31'b0, id_valid}, 32'h0);
        chk("fl1_addr", rom_addr,          32'h100);
        chk("fl1_ce",   {31'b0, rom_ce},   32'h1);
        chk("fl1_pc",   id_pc,             32'h0);
        chk("fl1_inst", id_inst,           32'h0);
        cyc();
        chk("fl2_vld",  {31'b0, id_valid}, 32'h1);
        chk("fl2_pc",   id_pc,             32'h100);
        chk("fl2_inst", id_inst,           32'h40);
        cyc();
        chk("fl3_pc",   id_pc,             32'h104);

        // Back-to-back flushes: the last target wins.
        flush = 1'b1; new_pc = 32'h200;
        cyc();
        new_pc = 32'h300;
        cyc();
        flush = 1'b0; stall = 1'b1;
        #1;
        chk("ff_addr", rom_addr,          32'h300);
        chk("ff_vld",  {31'b0, id_valid}, 32'h0);
        chk("ff_ce",   {31'b0, rom_ce},   32'h1);
        cyc();
        chk("ff1_vld",  {31'b0, id_valid}, 32'h1);
        chk("ff1_pc",   id_pc,             32'h300);
        chk("ff1_inst", id_inst,           32'hC0);
        cyc();
        chk("hold_pc",  id_pc,             32'h300);
        cyc();
        chk("q3_addr",  rom_addr,          32'h30C);

        // Reset mid-stream with three entries buffered.
        rst = 1'b1;
        #1;
        chk("mr_ce",  {31'b0, rom_ce},   32'h0);
        chk("mr_vld", {31'b0, id_valid}, 32'h0);
        cyc();
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("mr1_vld",  {31'b0, id_valid}, 32'h0);
        chk("mr1_pc",   id_pc,             32'h0);
        chk("mr1_inst", id_inst,           32'h0);
        chk("mr1_ce",   {31'b0, rom_ce},   32'h0);
        chk("mr1_addr", rom_addr,          32'h0);
        cyc();
        chk("mr2_ce",   {31'b0, rom_ce},   32'h1);
        chk("mr2_addr", rom_addr,          32'h0);
        cyc();
        chk("mr3_vld",  {31'b0, id_valid}, 32'h1);
        chk("mr3_pc",   id_pc,             32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
